instr_fetch_buffer: RTL and testbench
=====================================

Name: instr_fetch_buffer

Overview:
- Fetch-side consumer of the program counter's address output.
- Each cycle it may take the current PC value, issue a single-outstanding read to instruction memory, and queue the returned word tagged with its address.
- It drives the PC advance enable, so the PC only steps when a fetch is accepted.
- A flush input discards queued and in-flight fetches on a redirect (branch/jump reload of the PC).

Parameters:
- ADDR_W, 4, width of PC value / instruction memory address.
- DATA_W, 32, instruction word width.
- DEPTH, 4, instruction queue entries; power of two, >= 2.

Ports:
- clk  input  1  single clock, all state on rising edge.
- clr_n  input  1  asynchronous, active-high reset; 1 = reset asserted (name kept per codebase convention).
- pc_in  input  ADDR_W  current PC value.
- pc_ena  output  1  PC advance enable; 1 for exactly the cycle a fetch is granted.
- flush  input  1  redirect: drop queue and any in-flight response.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  ADDR_W  read address; equals pc_in while mem_req=1.
- mem_gnt  input  1  memory accepts request this cycle; ignored when mem_req=0.
- mem_rvalid  input  1  read data valid; at most one per granted request, at least 1 cycle after grant.
- mem_rdata  input  DATA_W  read data.
- instr_valid  output  1  queue head valid.
- instr_ready  input  1  downstream (decode) accepts head.
- instr_data  output  DATA_W  head instruction word.
- instr_pc  output  ADDR_W  address of head instruction.

Behaviour:
- Reset (clr_n=1, async): state=IDLE, queue count=0, read/write pointers=0, mem_req=0, pc_ena=0, instr_valid=0. instr_data and instr_pc = 0.
- FSM states:
  - IDLE: mem_req = (count < DEPTH) & ~flush. If mem_req & mem_gnt: pc_ena=1, latch mem_addr into req_pc, go WAIT.
  - WAIT: mem_req=0.
    - mem_rvalid & ~flush: push {req_pc, mem_rdata}, go IDLE.
    - mem_rvalid & flush: discard, go IDLE.
    - ~mem_rvalid & flush: go DROP.
  - DROP: mem_req=0. On mem_rvalid, discard data and go IDLE; flush in DROP has no further effect.
- A new request is issued no earlier than the cycle after a response. Best-case throughput is one instruction per 2 cycles with 1-cycle memory latency.
- pc_ena = mem_req & mem_gnt (combinational). The PC steps on the following edge.
- Queue: circular, DEPTH entries. count width = clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- instr_valid = (count != 0). instr_data and instr_pc come from the head entry.
- flush has priority over push and pop: count and pointers go to 0 on the next edge, and instr_valid=0 the cycle after flush.
- Full: count==DEPTH blocks issue (mem_req=0, pc_ena=0). Issue resumes the cycle after a pop makes count<DEPTH.
- Only one request is outstanding, and issue requires count<DEPTH, so a response is never dropped for lack of space.
- Reset mid-operation: all state cleared. Any memory response still pending after reset release is the memory's responsibility; this block, in IDLE, ignores mem_rvalid.

Optional Feature:
- FETCH_BYPASS_EN
  - Defined: in WAIT, if mem_rvalid & ~flush & count==0, the word is presented the same cycle: instr_valid=1, instr_data=mem_rdata, instr_pc=req_pc.
    - If instr_ready=1, the word is consumed and not pushed.
    - If instr_ready=0, it is pushed as normal.
  - Undefined: minimum latency from mem_rvalid to instr_valid is 1 cycle; the word is always pushed.

Test Plan:
- Reset then pc_in=3, mem_gnt=1, rvalid 1 cycle after grant with rdata=0x00A00093, instr_ready=1 -> pc_ena pulses once, instr_valid with instr_pc=3 and instr_data=0x00A00093 one cycle after rvalid (same cycle with FETCH_BYPASS_EN).
- instr_ready=0, DEPTH=4, memory always grants/responds -> exactly 4 grants (pc_ena pulses), then mem_req=0 holds. Raise instr_ready -> entries drain in address order; issue resumes the cycle after the first pop.
- flush asserted in WAIT before rvalid -> state DROP. Next rvalid (rdata=0xDEADBEEF) is not enqueued; instr_valid stays 0; next request issued with the new pc_in.
- flush coincident with rvalid while 2 entries queued -> count=0 next cycle, response discarded, no pc_ena that cycle.
- pc_in=15, grant, response, next pc_in=0 (PC wrap) -> instr_pc sequence 15, 0 with correct data.
- clr_n pulsed high while in WAIT with 3 entries queued -> instr_valid=0, mem_req=0 immediately (asynchronous). After release, a stray mem_rvalid is ignored and normal fetch restarts.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: single-outstanding instruction fetch with a tagged circular queue.
// Optional FETCH_BYPASS_EN presents a response on an empty queue in the same cycle.
module instr_fetch_buffer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_ena,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [ADDR_W-1:0] req_pc;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic              rsp;
    logic              byp;
    logic              head_valid;
    logic              push;
    logic              pop;

    // Request is held low while reset is asserted so the bus is quiet immediately.
    always_comb begin
        head_valid  = count != '0;
        mem_req     = ~clr_n & (state == IDLE) & (count < CW'(DEPTH)) & ~flush;
        pc_ena      = mem_req & mem_gnt;
        mem_addr    = pc_in;
        rsp         = (state == WAIT) & mem_rvalid & ~flush;
`ifdef FETCH_BYPASS_EN
        byp         = rsp & ~head_valid;
`else
        byp         = 1'b0;
`endif
        instr_valid = head_valid | byp;
        instr_data  = byp ? mem_rdata : data_q[rd_ptr];
        instr_pc    = byp ? req_pc : pc_q[rd_ptr];
        pop         = head_valid & instr_ready;
        push        = rsp & ~(byp & instr_ready);
    end

    always_ff @(posedge clk or posedge clr_n) begin
        if (clr_n) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            case (state)
                IDLE: if (pc_ena) begin
                    state  <= WAIT;
                    req_pc <= pc_in;
                end
                WAIT: state <= mem_rvalid ? IDLE : (flush ? DROP : WAIT);
                DROP: state <= mem_rvalid ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr_n) begin
        if (clr_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= mem_rdata;
                pc_q[wr_ptr]   <= req_pc;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: randomized bench against a transaction-level queue model.
module tb_instr_fetch_buffer;
    logic        clk = 0;
    logic        clr_n = 1;
    logic [3:0]  pc_in = 0;
    logic        pc_ena;
    logic        flush = 0;
    logic        mem_req;
    logic [3:0]  mem_addr;
    logic        mem_gnt = 0;
    logic        mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;
    logic        instr_valid;
    logic        instr_ready = 0;
    logic [31:0] instr_data;
    logic [3:0]  instr_pc;

    instr_fetch_buffer dut (
        .clk(clk), .clr_n(clr_n), .pc_in(pc_in), .pc_ena(pc_ena), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] pc; logic [31:0] d; } ent_t;
    ent_t        q[$];
    bit          out, drop, pend, stray, hit;
    int          dly, ngrant, tests, errs;
    logic [3:0]  rpc, pc;
    logic [31:0] pdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pf: flush percentage; rm: 0 = never ready, 1 = always ready, 2 = random
    task automatic cycle(input int pf, input int rm);
        bit f, r, g, rv, er, ee, byp, ev, o, d;
        logic [31:0] rd;
        ent_t h, e;
        @(negedge clk);
        f  = $urandom_range(99) < pf;
        r  = rm == 2 ? bit'($urandom_range(1)) : bit'(rm);
        g  = $urandom_range(99) < 70;
        rv = stray || (pend && dly == 0);
        rd = rv && !stray ? pdata : $urandom;
        flush = f; instr_ready = r; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; pc_in = pc;
        stray = 0;
        #1;
        er = !out && !drop && q.size() < 4 && !f;
        ee = er && g;
`ifdef FETCH_BYPASS_EN
        byp = out && rv && !f && q.size() == 0;
`else
        byp = 0;
`endif
        ev = q.size() > 0 || byp;
        if (byp) begin h.pc = rpc; h.d = rd; end
        else if (q.size() > 0) h = q[0];
        check("mem_req", mem_req, er);
        check("pc_ena", pc_ena, ee);
        if (er) check("mem_addr", mem_addr, pc);
        check("instr_valid", instr_valid, ev);
        if (ev) begin
            check("instr_pc", instr_pc, h.pc);
            check("instr_data", instr_data, h.d);
        end
        o = out; d = drop;
        if (f) q.delete();
        else if (q.size() > 0 && r) void'(q.pop_front());
        if (o && rv && !f && !(byp && r)) begin
            e.pc = rpc; e.d = rd;
            q.push_back(e);
        end
        drop = (d && !rv) || (o && !rv && f);
        out  = o && !rv && !f;
        if (ee) begin out = 1; rpc = pc; end
        if (pend && dly == 0) pend = 0;
        else if (pend) dly--;
        if (ee) begin
            pend  = 1;
            dly   = $urandom_range(0, 2);
            pdata = ngrant == 0 ? 32'h00A00093 : $urandom;
            ngrant++;
        end
        if (f) pc = 4'($urandom);
        else if (ee) pc = pc + 4'd1;
    endtask

    initial begin
        pc = 4'd3;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_data", instr_data, 0);
        check("rst_pc", instr_pc, 0);
        @(negedge clk);
        clr_n = 0;
        for (int i = 0; i < 300; i++) cycle(0, 2);
        for (int i = 0; i < 60; i++) cycle(0, 0);
        for (int i = 0; i < 60; i++) cycle(0, 1);
        for (int i = 0; i < 1500; i++) cycle(8, 2);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (q.size() == 3 && out) hit = 1;
            else cycle(0, 0);
        end
        check("reach3", hit, 1);
        @(negedge clk);
        #2 clr_n = 1;
        #1;
        check("async_req", mem_req, 0);
        check("async_valid", instr_valid, 0);
        q.delete(); out = 0; drop = 0; pend = 0;
        @(posedge clk);
        #1 clr_n = 0;
        stray = 1;
        for (int i = 0; i < 300; i++) cycle(5, 2);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
